// File: rtl/rv32im_bus_arbiter_pkg.sv
// rtl/rv32im_bus_arbiter_pkg.sv - shared Wishbone widths and master index constants
package rv32im_bus_arbiter_pkg;

  // Requester indices shared by the core top level and the bench
  localparam int MASTER_MEM      = 0;
  localparam int MASTER_PREFETCH = 1;
  localparam int MASTER_EXT0     = 2;
  localparam int MASTER_EXT1     = 3;

  // Wishbone slice widths
  localparam int WB_SEL_W = 4;

  // Word address width for a given data width
  function automatic int wb_adr_w(input int xlen);
    return xlen - 2;
  endfunction

endpackage

// File: rtl/rv32im_bus_watchdog.sv
// rtl/rv32im_bus_watchdog.sv - unanswered-strobe counter that fires a one-cycle err pulse
module rv32im_bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic cyc_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic clear_i,
  output logic fire_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;
  logic          pending;

  // A strobe is outstanding when the slave has answered neither ack nor err
  assign pending = cyc_i & stb_i & ~ack_i & ~err_i;

  // Fires once LIMIT unanswered cycles have elapsed and this cycle is still unanswered
  assign fire_o = (TIMEOUT != 0) && pending && (count_q == LIMIT) && !reset_i;

  // Next count: restart on any answer, idle strobe, grant change or fire; saturate at LIMIT
  always_comb begin
    count_d = count_q;
    if (!pending || clear_i || fire_o) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rv32im_bus_arbiter.sv
// rtl/rv32im_bus_arbiter.sv - Wishbone classic arbiter with parked default master and watchdog
module rv32im_bus_arbiter
  import rv32im_bus_arbiter_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter int          NUM_MASTERS    = 4,
  parameter int          DEFAULT_MASTER = MASTER_PREFETCH,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [NUM_MASTERS-1:0]            req_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  input  logic [NUM_MASTERS*(XLEN-2)-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*XLEN-1:0]       m_dat_i,
  input  logic [NUM_MASTERS*WB_SEL_W-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  output logic [XLEN-1:0]                   m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [XLEN-3:0]                   adr_o,
  output logic [XLEN-1:0]                   dat_o,
  output logic [WB_SEL_W-1:0]               sel_o,
  output logic                              cyc_o,
  output logic                              stb_o,
  output logic                              we_o,
  input  logic [XLEN-1:0]                   dat_i,
  input  logic                              ack_i,
  input  logic                              err_i,
  output logic                              timeout_o
);

  localparam int AW = XLEN - 2;
  localparam logic [NUM_MASTERS-1:0] DEFAULT_ONEHOT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] lowest_req;
  logic                   any_req;
  logic                   owner_cyc;
  logic                   wd_fire;

  assign grant_o   = grant_q;
  assign owner_cyc = |(grant_q & m_cyc_i);

  // Lowest-index requester wins; index 0 has highest priority
  always_comb begin
    lowest_req = '0;
    any_req    = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (req_i[k] && !any_req) begin
        lowest_req[k] = 1'b1;
        any_req       = 1'b1;
      end
    end
  end

  // Next grant: locked while the owner holds cyc; non-default owners always return via the park
  always_comb begin
    grant_d = grant_q;
    if (!owner_cyc) begin
      if (grant_q == DEFAULT_ONEHOT) begin
        if (!req_i[DEFAULT_MASTER] && any_req) begin
          grant_d = lowest_req;
        end
      end else if (!(|(grant_q & req_i))) begin
        grant_d = DEFAULT_ONEHOT;
      end
    end
  end

  // Grant register, parked on the default master out of reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_q <= DEFAULT_ONEHOT;
    end else begin
      grant_q <= grant_d;
    end
  end

  // Slave-side mux selects the owner's slice; grant is one-hot so OR-ing is exact
  always_comb begin
    adr_o = '0;
    dat_o = '0;
    sel_o = '0;
    cyc_o = 1'b0;
    stb_o = 1'b0;
    we_o  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        adr_o = adr_o | m_adr_i[k*AW +: AW];
        dat_o = dat_o | m_dat_i[k*XLEN +: XLEN];
        sel_o = sel_o | m_sel_i[k*WB_SEL_W +: WB_SEL_W];
        cyc_o = cyc_o | m_cyc_i[k];
        stb_o = stb_o | m_stb_i[k];
        we_o  = we_o  | m_we_i[k];
      end
    end
  end

  rv32im_bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .cyc_i  (cyc_o),
    .stb_i  (stb_o),
    .ack_i  (ack_i),
    .err_i  (err_i),
    .clear_i(grant_d != grant_q),
    .fire_o (wd_fire)
  );

  // Responses go to the owner only and are suppressed while reset is held
  assign m_dat_o   = dat_i;
  assign m_ack_o   = reset_i ? '0 : ({NUM_MASTERS{ack_i}} & grant_q);
  assign m_err_o   = reset_i ? '0 : ({NUM_MASTERS{err_i | wd_fire}} & grant_q);
  assign timeout_o = wd_fire;

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// tb/tb_rv32im_bus_arbiter.sv - directed scoreboard bench for the bus arbiter
module tb_rv32im_bus_arbiter;
  import rv32im_bus_arbiter_pkg::*;

  localparam int XLEN = 32;
  localparam int NM   = 4;
  localparam int AW   = XLEN - 2;
  localparam int TO   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     req, grant, cyc, stb, we, m_ack, m_err;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*XLEN-1:0] m_dat;
  logic [NM*4-1:0]   m_sel;
  logic [XLEN-1:0]   m_dat_o, dat_o, dat_i;
  logic [AW-1:0]     adr_o;
  logic [3:0]        sel_o;
  logic              cyc_o, stb_o, we_o, ack_i, err_i, timeout;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 clk = ~clk;

  rv32im_bus_arbiter #(
    .XLEN(XLEN), .NUM_MASTERS(NM), .DEFAULT_MASTER(MASTER_PREFETCH), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .grant_o(grant),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .timeout_o(timeout)
  );

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h required <none>", obs);
    end else begin
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, e);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req = '0; cyc = '0; stb = '0; we = '0;
    dat_i = 32'hCAFE_0000; ack_i = 1'b0; err_i = 1'b0;
    for (int k = 0; k < NM; k++) begin
      m_adr[k*AW +: AW]     = AW'(32'h100 + k);
      m_dat[k*XLEN +: XLEN] = 32'hD000_0000 + k;
      m_sel[k*4 +: 4]       = 4'(k + 1);
    end
    step(); step();

    // Reset state and response gating during reset
    ack_i = 1'b1;
    expect_val("reset_ack_gated", 32'h0);
    expect_val("reset_grant", 32'h2);
    #1 check(32'(m_ack)); check(32'(grant));
    ack_i = 1'b0;
    reset = 1'b0;
    expect_val("idle_grant", 32'h2);
    expect_val("idle_timeout", 32'h0);
    #1 check(32'(grant)); check(32'(timeout));
    cyc[1] = 1'b1;
    expect_val("default_cyc_follow", 32'h1);
    expect_val("default_adr_follow", 32'h101);
    expect_val("dat_broadcast", 32'hCAFE_0000);
    #1 check(32'(cyc_o)); check(32'(adr_o)); check(m_dat_o);
    cyc[1] = 1'b0;

    // Simultaneous requests: index 0 wins after one cycle
    req = 4'b1101;
    expect_val("req_latency", 32'h2);
    #1 check(32'(grant));
    step();
    expect_val("grant_m0", 32'h1);
    expect_val("mux_adr_m0", 32'h100);
    expect_val("mux_sel_m0", 32'h1);
    #1 check(32'(grant)); check(32'(adr_o)); check(32'(sel_o));
    ack_i = 1'b1;
    expect_val("ack_route_m0", 32'h1);
    #1 check(32'(m_ack));
    ack_i = 1'b0;

    // Lock: master 0 drops req but keeps cyc for three cycles
    cyc[0] = 1'b1;
    req = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_val("lock_hold", 32'h1);
      #1 check(32'(grant));
    end
    cyc[0] = 1'b0;
    expect_val("lock_release_same_cycle", 32'h1);
    #1 check(32'(grant));
    step();
    expect_val("park_between_owners", 32'h2);
    #1 check(32'(grant));
    step();
    expect_val("grant_m2", 32'h4);
    #1 check(32'(grant));

    // Watchdog: slave never answers; err at offset 8, restart, again at 17
    cyc[2] = 1'b1; stb[2] = 1'b1;
    for (int off = 0; off < 18; off++) begin
      expect_val($sformatf("wd_err_off%0d", off), (off == 8 || off == 17) ? 32'h4 : 32'h0);
      expect_val($sformatf("wd_timeout_off%0d", off), (off == 8 || off == 17) ? 32'h1 : 32'h0);
      #1 check(32'(m_err)); check(32'(timeout));
      step();
    end
    stb[2] = 1'b0; cyc[2] = 1'b0;
    step();

    // Ack arrives on the cycle the watchdog would fire: ack wins
    cyc[2] = 1'b1; stb[2] = 1'b1;
    repeat (8) step();
    ack_i = 1'b1;
    expect_val("late_ack_m2", 32'h4);
    expect_val("late_ack_no_err", 32'h0);
    expect_val("late_ack_no_timeout", 32'h0);
    #1 check(32'(m_ack)); check(32'(m_err)); check(32'(timeout));
    ack_i = 1'b0; err_i = 1'b1;
    expect_val("err_passthrough", 32'h4);
    #1 check(32'(m_err));
    err_i = 1'b0; stb[2] = 1'b0; cyc[2] = 1'b0;

    // Reset while master 3 owns the bus mid-cycle
    req = 4'b1000;
    step();
    expect_val("m2_release_park", 32'h2);
    #1 check(32'(grant));
    step();
    expect_val("grant_m3", 32'h8);
    #1 check(32'(grant));
    cyc[3] = 1'b1; stb[3] = 1'b1;
    repeat (3) step();
    expect_val("wd_count_midcycle", 32'h3);
    #1 check(32'(dut.u_watchdog.count_q));
    reset = 1'b1; ack_i = 1'b1;
    expect_val("reset_mid_ack", 32'h0);
    expect_val("reset_mid_err", 32'h0);
    #1 check(32'(m_ack)); check(32'(m_err));
    step();
    expect_val("reset_mid_grant", 32'h2);
    expect_val("reset_mid_count", 32'h0);
    #1 check(32'(grant)); check(32'(dut.u_watchdog.count_q));
    reset = 1'b0; ack_i = 1'b0; cyc = '0; stb = '0; req = '0;
    step();
    expect_val("idle_after_reset", 32'h2);
    #1 check(32'(grant));

    if (exp_q.size() != 0) begin
      n_total++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
